// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

  typedef enum logic {
    StIdle,
    StAccess
  } state_e;

  localparam logic PortCpu = 1'b0;
  localparam logic PortDma = 1'b1;

  localparam int unsigned SizeData = 32;

  function automatic logic is_aligned(input logic [1:0] byte_off);
    return byte_off == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-requester round-robin picker: combinational grant, registered priority pointer.
module dmem_arbiter_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       gnt_o,
  output logic       valid_o
);

  // ptr_q names the port that wins a tie.
  logic ptr_q, ptr_d;

  always_comb begin
    valid_o = |req_i;
    unique case (req_i)
      2'b01:   gnt_o = 1'b0;
      2'b10:   gnt_o = 1'b1;
      2'b11:   gnt_o = ptr_q;
      default: gnt_o = 1'b0;
    endcase
    ptr_d = (update_i && valid_o) ? ~gnt_o : ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-ported data memory between the CPU LSU (port 0) and a DMA/loader (port 1).
module dmem_arbiter #(
  parameter int unsigned DATA_W    = dmem_arbiter_pkg::SizeData,
  parameter int unsigned ADDR_BITS = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we0,
  input  logic              we1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_out
);
  import dmem_arbiter_pkg::*;

  // The memory wraps on its own; the word index must still fit in the address bus.
  if (ADDR_BITS + 2 > DATA_W) begin : g_bad_addr_bits
    $error("ADDR_BITS does not fit in DATA_W");
  end

  state_e            state_q;
  logic              grant_q;
  logic              ack0_q, ack1_q, err0_q, err1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic [DATA_W-1:0] addr_g, wdata_g;
  logic              we_g, aligned, in_access;
  logic [1:0]        eligible;
  logic              arb_gnt, arb_valid, arb_update;

  // A port is masked during its own ack cycle so a held req is not double-served.
  assign eligible   = {req1 & ~ack1_q, req0 & ~ack0_q};
  assign arb_update = (state_q == StIdle);

  dmem_arbiter_rr_arbiter2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .req_i    (eligible),
    .update_i (arb_update),
    .gnt_o    (arb_gnt),
    .valid_o  (arb_valid)
  );

  always_comb begin
    addr_g    = (grant_q == PortDma) ? addr1  : addr0;
    wdata_g   = (grant_q == PortDma) ? wdata1 : wdata0;
    we_g      = (grant_q == PortDma) ? we1    : we0;
    aligned   = is_aligned(addr_g[1:0]);
    in_access = (state_q == StAccess);

    mem_access_addr = in_access ? addr_g  : '0;
    mem_in          = in_access ? wdata_g : '0;
    mem_write_en    = in_access &&  we_g && aligned;
    mem_read_en     = in_access && !we_g && aligned;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= PortCpu;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (arb_valid) begin
            grant_q <= arb_gnt;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          if (grant_q == PortCpu) begin
            ack0_q <= 1'b1;
            err0_q <= ~aligned;
            if (!we_g) rdata0_q <= aligned ? mem_out : '0;
          end else begin
            ack1_q <= 1'b1;
            err1_q <= ~aligned;
            if (!we_g) rdata1_q <= aligned ? mem_out : '0;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign err0   = err0_q;
  assign err1   = err1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a transaction-level memory/port model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_v = '0;
  logic [1:0]  we_v = '0;
  logic [31:0] addr_v [2];
  logic [31:0] wdata_v [2];

  logic        ack0, ack1, err0, err1, mem_write_en, mem_read_en;
  logic [31:0] rdata0, rdata1, mem_access_addr, mem_in, mem_out;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] ref_mem [32];
  logic [31:0] exp_rdata [2];
  logic        exp_err [2];
  int          last_grant;

  // Behavioural memory attached to the DUT
  logic [31:0] bmem [32];
  logic        mem_init = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .req0            (req_v[0]),
    .req1            (req_v[1]),
    .addr0           (addr_v[0]),
    .addr1           (addr_v[1]),
    .wdata0          (wdata_v[0]),
    .wdata1          (wdata_v[1]),
    .we0             (we_v[0]),
    .we1             (we_v[1]),
    .ack0            (ack0),
    .ack1            (ack1),
    .rdata0          (rdata0),
    .rdata1          (rdata1),
    .err0            (err0),
    .err1            (err1),
    .mem_access_addr (mem_access_addr),
    .mem_in          (mem_in),
    .mem_write_en    (mem_write_en),
    .mem_read_en     (mem_read_en),
    .mem_out         (mem_out)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  assign mem_out = bmem[mem_access_addr[6:2]];

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) bmem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (mem_write_en) begin
      bmem[mem_access_addr[6:2]] <= mem_in;
    end
  end

  function automatic void model_reset();
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    exp_err[0]   = 1'b0;
    exp_err[1]   = 1'b0;
    last_grant   = 1;
  endfunction

  // Apply one completed access in service order.
  function automatic void model_apply(input int p, input logic [31:0] a, input logic [31:0] d,
                                      input logic w);
    logic al;
    al = (a[1:0] == 2'b00);
    exp_err[p] = !al;
    last_grant = p;
    if (w) begin
      if (al) ref_mem[a[6:2]] = d;
    end else begin
      exp_rdata[p] = al ? ref_mem[a[6:2]] : 32'h0;
    end
  endfunction

  function automatic logic ack_of(input int p);
    return (p == 1) ? ack1 : ack0;
  endfunction

  function automatic logic err_of(input int p);
    return (p == 1) ? err1 : err0;
  endfunction

  function automatic logic [31:0] rdata_of(input int p);
    return (p == 1) ? rdata1 : rdata0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_single(input int p, input logic [31:0] a, input logic [31:0] d,
                           input logic w, input string name);
    int   lat, wen, ren;
    logic got, al;
    al = (a[1:0] == 2'b00);
    req_v[p] = 1'b1; addr_v[p] = a; wdata_v[p] = d; we_v[p] = w;
    lat = 0; wen = 0; ren = 0; got = 1'b0;
    while (!got && lat < 10) begin
      tick();
      lat++;
      if (mem_write_en) wen++;
      if (mem_read_en) ren++;
      if (ack_of(p)) got = 1'b1;
    end
    req_v[p] = 1'b0;
    model_apply(p, a, d, w);
    n_checks++;
    if (!got || lat !== 2) begin
      n_errors++; $display("FAIL %s latency: got %0d (ack seen %0b) expected 2", name, lat, got);
    end
    n_checks++;
    if (err_of(p) !== exp_err[p]) begin
      n_errors++; $display("FAIL %s err: got %b expected %b", name, err_of(p), exp_err[p]);
    end
    n_checks++;
    if (rdata_of(p) !== exp_rdata[p]) begin
      n_errors++; $display("FAIL %s rdata: got %h expected %h", name, rdata_of(p), exp_rdata[p]);
    end
    n_checks++;
    if (wen !== ((w && al) ? 1 : 0) || ren !== ((!w && al) ? 1 : 0)) begin
      n_errors++;
      $display("FAIL %s enables: got we=%0d re=%0d cycles expected we=%0d re=%0d", name, wen, ren,
               (w && al) ? 1 : 0, (!w && al) ? 1 : 0);
    end
    tick();
    n_checks++;
    if (ack_of(p) !== 1'b0) begin
      n_errors++; $display("FAIL %s ack pulse: got %b one cycle later expected 0", name, ack_of(p));
    end
  endtask

  task automatic test_reset();
    logic saw_ack;
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
    tick();
    n_checks++;
    if ({ack0, ack1, err0, err1} !== 4'b0) begin
      n_errors++; $display("FAIL reset ack/err: got %b expected 0000", {ack0, ack1, err0, err1});
    end
    n_checks++;
    if ({mem_write_en, mem_read_en} !== 2'b0 || mem_access_addr !== 32'h0) begin
      n_errors++;
      $display("FAIL reset mem: got we=%b re=%b addr=%h expected all 0", mem_write_en,
               mem_read_en, mem_access_addr);
    end
    n_checks++;
    if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
      n_errors++; $display("FAIL reset rdata: got %h %h expected 0 0", rdata0, rdata1);
    end
    // Abandon a write in its ACCESS cycle
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'hC; wdata_v[0] = 32'hA5A5_5A5A;
    tick();
    n_checks++;
    if (mem_write_en !== 1'b1) begin
      n_errors++; $display("FAIL midreset access: got mem_write_en=%b expected 1", mem_write_en);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (mem_write_en !== 1'b0 || mem_access_addr !== 32'h0) begin
      n_errors++;
      $display("FAIL midreset drop: got we=%b addr=%h expected 0 0", mem_write_en, mem_access_addr);
    end
    req_v = '0;
    tick();
    rst = 1'b0;
    model_reset();
    saw_ack = 1'b0;
    repeat (4) begin
      tick();
      if (ack0 || ack1) saw_ack = 1'b1;
    end
    n_checks++;
    if (saw_ack !== 1'b0) begin
      n_errors++; $display("FAIL midreset noack: got ack seen=%b expected 0", saw_ack);
    end
    do_single(0, 32'hC, 32'h0, 1'b0, "midreset readback");
  endtask

  task automatic test_write_read();
    do_single(0, 32'h8, 32'hDEAD_BEEF, 1'b1, "p0 write");
    do_single(0, 32'h8, 32'h0, 1'b0, "p0 read");
    do_single(1, 32'h14, 32'h0BAD_F00D, 1'b1, "p1 write");
    do_single(1, 32'h14, 32'h0, 1'b0, "p1 read");
  endtask

  task automatic test_misaligned();
    do_single(1, 32'h6, 32'h0, 1'b0, "p1 misaligned read");
    do_single(0, 32'h9, 32'h5555_AAAA, 1'b1, "p0 misaligned write");
    do_single(0, 32'h8, 32'h0, 1'b0, "p0 after misaligned write");
  endtask

  task automatic test_wrap();
    do_single(0, 32'h80, 32'h5, 1'b1, "wrap write");
    do_single(0, 32'h0, 32'h0, 1'b0, "wrap read");
  endtask

  task automatic test_contention();
    int   acks, cyc, p, exp_p;
    logic coincide;
    do_single(0, 32'h4, 32'h11, 1'b1, "preload");
    req_v = 2'b11; we_v = 2'b00;
    addr_v[0] = 32'h10; addr_v[1] = 32'h4;
    exp_p = 1 - last_grant;
    acks = 0; cyc = 0; coincide = 1'b0;
    while (acks < 4 && cyc < 20) begin
      tick();
      cyc++;
      if (ack0 && ack1) coincide = 1'b1;
      if (ack0 || ack1) begin
        p = ack1 ? 1 : 0;
        model_apply(p, addr_v[p], wdata_v[p], we_v[p]);
        n_checks++;
        if (p !== exp_p) begin
          n_errors++; $display("FAIL contention order #%0d: got port %0d expected %0d", acks, p, exp_p);
        end
        n_checks++;
        if (rdata_of(p) !== exp_rdata[p] || err_of(p) !== 1'b0) begin
          n_errors++;
          $display("FAIL contention data port %0d: got %h err=%b expected %h err=0", p,
                   rdata_of(p), err_of(p), exp_rdata[p]);
        end
        exp_p = 1 - p;
        acks++;
        if (acks == 4) req_v = '0;
      end
    end
    req_v = '0;
    n_checks++;
    if (acks !== 4 || coincide !== 1'b0) begin
      n_errors++; $display("FAIL contention count: got %0d acks coincide=%b expected 4 0", acks, coincide);
    end
    n_checks++;
    if (rdata1 !== 32'h11) begin
      n_errors++; $display("FAIL contention rdata1: got %h expected 00000011", rdata1);
    end
    tick();
  endtask

  task automatic test_held_request();
    int   c1, c2, cyc;
    logic ren_hist [16];
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 32'h8;
    c1 = -1; c2 = -1; cyc = 0;
    while (c2 < 0 && cyc < 15) begin
      tick();
      ren_hist[cyc] = mem_read_en;
      if (ack0) begin
        model_apply(0, addr_v[0], wdata_v[0], we_v[0]);
        n_checks++;
        if (rdata0 !== exp_rdata[0]) begin
          n_errors++; $display("FAIL held rdata: got %h expected %h", rdata0, exp_rdata[0]);
        end
        if (c1 < 0) c1 = cyc;
        else begin c2 = cyc; req_v[0] = 1'b0; end
      end
      cyc++;
    end
    req_v[0] = 1'b0;
    n_checks++;
    if (c1 < 0 || c2 - c1 !== 3) begin
      n_errors++; $display("FAIL held spacing: got ack cycles %0d,%0d expected gap 3", c1, c2);
    end else begin
      n_checks++;
      if (ren_hist[c1 + 1] !== 1'b0 || ren_hist[c1 + 2] !== 1'b1) begin
        n_errors++;
        $display("FAIL held regrant: got read_en %b,%b after ack expected 0,1",
                 ren_hist[c1 + 1], ren_hist[c1 + 2]);
      end
    end
    tick();
  endtask

  task automatic test_random();
    logic busy [2];
    int   start [2];
    busy[0] = 1'b0; busy[1] = 1'b0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      tick();
      if (ack0 && ack1) begin
        n_checks++; n_errors++; $display("FAIL random coincident acks at cycle %0d", cyc);
      end
      for (int p = 0; p < 2; p++) begin
        if (ack_of(p)) begin
          n_checks++;
          if (!busy[p]) begin
            n_errors++; $display("FAIL random spurious ack port %0d: got 1 expected 0", p);
          end else begin
            model_apply(p, addr_v[p], wdata_v[p], we_v[p]);
            if (rdata_of(p) !== exp_rdata[p] || err_of(p) !== exp_err[p] || cyc - start[p] > 6) begin
              n_errors++;
              $display("FAIL random port %0d: got rdata=%h err=%b lat=%0d expected %h %b <=6", p,
                       rdata_of(p), err_of(p), cyc - start[p], exp_rdata[p], exp_err[p]);
            end
          end
          busy[p] = 1'b0;
          req_v[p] = 1'b0;
        end else if (busy[p] && cyc - start[p] > 8) begin
          n_checks++; n_errors++;
          $display("FAIL random timeout port %0d: got no ack expected ack within 6", p);
          busy[p] = 1'b0;
          req_v[p] = 1'b0;
        end
        if (err_of(p) && !ack_of(p)) begin
          n_checks++; n_errors++; $display("FAIL random err without ack port %0d", p);
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (!busy[p] && cyc < 400 && $urandom_range(0, 2) == 0) begin
          addr_v[p]  = $urandom_range(0, 63) * 4;
          if ($urandom_range(0, 5) == 0) addr_v[p] = addr_v[p] + $urandom_range(1, 3);
          wdata_v[p] = $urandom;
          we_v[p]    = $urandom_range(0, 1) == 1;
          req_v[p]   = 1'b1;
          busy[p]    = 1'b1;
          start[p]   = cyc;
        end
      end
    end
    req_v = '0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
    addr_v[0] = '0; addr_v[1] = '0; wdata_v[0] = '0; wdata_v[1] = '0;
    model_reset();
    test_reset();
    test_write_read();
    test_misaligned();
    test_wrap();
    test_contention();
    test_held_request();
    test_random();
    test_contention();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
